// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: frame geometry, read/write flag
// polarity, FSM state encoding and the frame-building helper.
package spi_master_pkg;

    localparam int   FRAME_BITS = 16;
    localparam int   ADDR_BITS  = 7;
    localparam int   DATA_BITS  = 8;
    localparam logic RW_READ    = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT_HI = 3'd2,
        SHIFT_LO = 3'd3,
        HOLD     = 3'd4,
        GAP      = 3'd5
    } state_e;

    // Command byte is {addr, rw}; the data byte is zero for reads so the
    // slave sees a clean dummy byte while it drives MISO.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [ADDR_BITS-1:0] addr,
        input logic                 rw,
        input logic [DATA_BITS-1:0] wdata
    );
        logic [DATA_BITS-1:0] data_byte;
        data_byte   = (rw == RW_READ) ? '0 : wdata;
        build_frame = {addr, rw, data_byte};
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// Host-side handshake bundle of the SPI master. The host drives the request
// fields; the master returns status and read data.
interface spi_master_if;
    import spi_master_pkg::*;

    logic                 start;
    logic                 rw;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
    logic                 busy;
    logic                 done;
    logic [DATA_BITS-1:0] rdata;

    // Host (request issuer) side.
    modport master (
        output start, rw, addr, wdata,
        input  busy, done, rdata
    );

    // SPI master (request consumer) side.
    modport slave (
        input  start, rw, addr, wdata,
        output busy, done, rdata
    );

endinterface

// File: rtl/spi_sclk_gen.sv
// Half-period timebase for the SPI master. Counts 0..HALF_PERIOD-1 while
// running and wraps, so every phase is exactly HALF_PERIOD clk cycles long.
// All strobes fire in the last cycle of a phase, i.e. one cycle before the
// corresponding SCLK edge appears on the registered state.
module spi_sclk_gen #(
    parameter int unsigned HALF_PERIOD = 8   // legal 4..255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run_i,      // counter active (any non-idle state)
    input  logic sclk_hi_i,  // current phase drives SCLK high
    input  logic edge_ok_i,  // a rising edge may follow this low phase
    output logic tick_o,     // last cycle of the current phase
    output logic rise_o,     // SCLK rises next cycle
    output logic fall_o,     // SCLK falls next cycle
    output logic sample_o    // last cycle of a high phase: MISO sample point
);

    localparam logic [7:0] LAST = 8'(HALF_PERIOD - 1);

    logic [7:0] cnt_q, cnt_d;

    // Next count: hold at zero when idle, wrap at the end of each phase.
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Phase-end strobes, qualified by the current SCLK level.
    always_comb begin
        tick_o   = run_i && (cnt_q == LAST);
        rise_o   = tick_o && !sclk_hi_i && edge_ok_i;
        fall_o   = tick_o && sclk_hi_i;
        sample_o = tick_o && sclk_hi_i;
    end

endmodule

// File: rtl/spi_master.sv
// SPI master (mode 0, MSB first) issuing 16-bit frames {addr, rw, data}.
// Sequence: IDLE -> SETUP -> (SHIFT_HI <-> SHIFT_LO) x16 -> HOLD -> GAP -> IDLE,
// each phase HALF_PERIOD clk cycles. All pin outputs decode directly from
// registered state, so they change only on clk edges.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 8   // clk cycles per SCLK half-period, 4..255
) (
    input  logic        clk,
    input  logic        reset_n,
    spi_master_if.slave host,
    output logic        sclk_pin,
    output logic        cs_pin,
    output logic        mosi_pin,
    input  logic        miso_pin
);

    localparam int                 BIT_W        = $clog2(FRAME_BITS);
    localparam logic [BIT_W-1:0]   LAST_BIT     = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0]   FIRST_RX_BIT = BIT_W'(FRAME_BITS - DATA_BITS);

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic [BIT_W-1:0]        bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0]    rx_q, rx_d;
    logic [DATA_BITS-1:0]    rdata_q, rdata_d;
    logic                    rw_q, rw_d;
    logic                    done_q, done_d;

    logic run;
    logic sclk_hi;
    logic edge_ok;
    logic tick;
    logic rise;
    logic fall;
    logic sample;

    // Timebase control: run outside IDLE; after the 16th period the low
    // phase leads into HOLD instead of another rising edge.
    always_comb begin
        run     = (state_q != IDLE);
        sclk_hi = (state_q == SHIFT_HI);
        edge_ok = (state_q == SETUP) ||
                  ((state_q == SHIFT_LO) && (bitcnt_q != LAST_BIT));
    end

    spi_sclk_gen #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_sclk_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .run_i     (run),
        .sclk_hi_i (sclk_hi),
        .edge_ok_i (edge_ok),
        .tick_o    (tick),
        .rise_o    (rise),
        .fall_o    (fall),
        .sample_o  (sample)
    );

    // FSM state register; reset wins over everything, including a pending start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; start is only looked at in IDLE, so requests
    // during a frame are dropped rather than queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (host.start) state_d = SETUP;
            SETUP:    if (rise)       state_d = SHIFT_HI;
            SHIFT_HI: if (fall)       state_d = SHIFT_LO;
            SHIFT_LO: if (tick)       state_d = rise ? SHIFT_HI : HOLD;
            HOLD:     if (tick)       state_d = GAP;
            GAP:      if (tick)       state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // FSM outputs: pins and status decoded from the registered state.
    always_comb begin
        sclk_pin   = (state_q == SHIFT_HI);
        cs_pin     = !((state_q == SETUP) || (state_q == SHIFT_HI) ||
                       (state_q == SHIFT_LO) || (state_q == HOLD));
        mosi_pin   = shreg_q[FRAME_BITS-1];
        host.busy  = (state_q != IDLE);
        host.done  = done_q;
        host.rdata = rdata_q;
    end

    // Shift datapath next state: load the frame on acceptance, shift MOSI
    // on each falling edge (zero-filled, so MOSI idles at 0 after bit 0),
    // capture MISO in the second byte, publish read data as done rises.
    always_comb begin
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        rx_d     = rx_q;
        rdata_d  = rdata_q;
        rw_d     = rw_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (host.start) begin
                    shreg_d  = build_frame(host.addr, host.rw, host.wdata);
                    rw_d     = host.rw;
                    bitcnt_d = '0;
                    rx_d     = '0;
                end
            end
            SHIFT_HI: begin
                if (fall) begin
                    shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
                end
                if (sample && (bitcnt_q >= FIRST_RX_BIT)) begin
                    rx_d = {rx_q[DATA_BITS-2:0], miso_pin};
                end
            end
            SHIFT_LO: begin
                if (rise) begin
                    bitcnt_d = bitcnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (tick) begin
                    done_d = 1'b1;
                    if (rw_q == RW_READ) begin
                        rdata_d = rx_q;
                    end
                end
            end
            default: ;
        endcase
    end

    // Shift datapath registers; reset clears everything so an aborted
    // frame leaves no trace in rdata.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shreg_q  <= '0;
            bitcnt_q <= '0;
            rx_q     <= '0;
            rdata_q  <= '0;
            rw_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            rx_q     <= rx_d;
            rdata_q  <= rdata_d;
            rw_q     <= rw_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a pin-level SPI memory slave plus per-transaction
// timing and data expectations derived from the frame/phase rules.
module tb_spi_master;
    import spi_master_pkg::*;

    localparam int unsigned HP    = 8;
    localparam int          T_LEN = 35 * HP + 1;   // cycles from acceptance to next acceptance

    logic clk      = 1'b0;
    logic reset_n  = 1'b0;
    logic sclk_pin;
    logic cs_pin;
    logic mosi_pin;
    logic miso_pin = 1'b0;

    spi_master_if hif();

    spi_master #(
        .HALF_PERIOD (HP)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .host     (hif),
        .sclk_pin (sclk_pin),
        .cs_pin   (cs_pin),
        .mosi_pin (mosi_pin),
        .miso_pin (miso_pin)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // SPI memory slave model: captures MOSI on SCLK rises, after the
    // command byte drives the addressed byte on MISO at each falling edge,
    // and commits writes when CS rises after a complete 16-bit frame.
    logic [7:0]  mem [128];
    logic        prev_sclk   = 1'b0;
    logic        prev_cs     = 1'b1;
    logic        prev_mosi   = 1'b0;
    int          rises       = 0;
    int          frames_seen = 0;
    int          viol        = 0;
    logic [15:0] cap         = '0;
    logic [15:0] last_frame  = '0;
    logic [7:0]  rd_byte     = '0;

    always @(negedge clk) begin
        if (prev_sclk && sclk_pin && (mosi_pin !== prev_mosi || cs_pin !== prev_cs)) viol++;
        if (cs_pin !== 1'b0) begin
            if (prev_cs == 1'b0 && rises == 16) begin
                last_frame = cap;
                frames_seen++;
                if (cap[8] == 1'b0) mem[cap[15:9]] = cap[7:0];
            end
            rises    = 0;
            miso_pin = 1'b0;
        end else begin
            if (sclk_pin && !prev_sclk) begin
                cap = {cap[14:0], mosi_pin};
                rises++;
            end
            if (!sclk_pin && prev_sclk && rises >= 8 && rises <= 15) begin
                if (rises == 8) rd_byte = mem[cap[7:1]];
                miso_pin = rd_byte[3'(15 - rises)];
            end
        end
        prev_sclk = sclk_pin;
        prev_cs   = cs_pin;
        prev_mosi = mosi_pin;
    end

    logic [7:0] exp_rdata = 8'h00;

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (hif.busy !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_idle"}, 32'(hif.busy), 32'd0);
    endtask

    // One transaction from acceptance (cycle 0) to the cycle busy drops.
    // Inputs are scrambled after acceptance; spur > 0 pulses start at that cycle.
    task automatic run_txn(input logic rw_v, input logic [6:0] a, input logic [7:0] wd,
                           input int spur, input string tag);
        int          cs_first, cs_last, done_n, done_cyc, busy_fall, first_hi, hi_cyc, fs0;
        logic        cs_at_done, mosi_at_done;
        logic [7:0]  rd_at_done, exp_rd;
        logic [15:0] exp_frame;
        cs_first = 0; cs_last = 0; done_n = 0; done_cyc = 0; busy_fall = 0;
        first_hi = 0; hi_cyc = 0;
        cs_at_done = 1'b0; mosi_at_done = 1'b1; rd_at_done = 8'hxx;
        exp_frame = {a, rw_v, (rw_v ? 8'h00 : wd)};
        wait_idle(tag);
        exp_rd = rw_v ? mem[a] : exp_rdata;
        fs0 = frames_seen;
        hif.start = 1'b1; hif.rw = rw_v; hif.addr = a; hif.wdata = wd;
        for (int c = 1; c <= T_LEN; c++) begin
            @(negedge clk);
            if (cs_pin == 1'b0) begin
                if (cs_first == 0) cs_first = c;
                cs_last = c;
            end
            if (hif.done) begin
                done_n++;
                done_cyc     = c;
                cs_at_done   = cs_pin;
                mosi_at_done = mosi_pin;
                rd_at_done   = hif.rdata;
            end
            if (!hif.busy && busy_fall == 0) busy_fall = c;
            if (sclk_pin) begin
                hi_cyc++;
                if (first_hi == 0) first_hi = c;
            end
            hif.start = (c == spur);
            hif.rw    = 1'($urandom);
            hif.addr  = 7'($urandom);
            hif.wdata = 8'($urandom);
        end
        hif.start = 1'b0;
        check_eq({tag, "_cs_first"},  32'(cs_first),     32'd1);
        check_eq({tag, "_cs_last"},   32'(cs_last),      32'(34 * HP));
        check_eq({tag, "_sclk_first"},32'(first_hi),     32'(HP + 1));
        check_eq({tag, "_sclk_hi"},   32'(hi_cyc),       32'(16 * HP));
        check_eq({tag, "_done_n"},    32'(done_n),       32'd1);
        check_eq({tag, "_done_cyc"},  32'(done_cyc),     32'(34 * HP + 1));
        check_eq({tag, "_cs_done"},   32'(cs_at_done),   32'd1);
        check_eq({tag, "_mosi_done"}, 32'(mosi_at_done), 32'd0);
        check_eq({tag, "_busy_fall"}, 32'(busy_fall),    32'(35 * HP + 1));
        check_eq({tag, "_frames"},    32'(frames_seen),  32'(fs0 + 1));
        check_eq({tag, "_frame"},     32'(last_frame),   32'(exp_frame));
        check_eq({tag, "_rdata"},     32'(rd_at_done),   32'(exp_rd));
        exp_rdata = exp_rd;
    endtask

    initial begin
        int dq[$];
        int fs0, dn, csl;
        hif.start = 1'b0; hif.rw = 1'b0; hif.addr = '0; hif.wdata = '0;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        mem[3] = 8'h3C;

        repeat (3) @(negedge clk);
        check_eq("rst_cs",    32'(cs_pin),    32'd1);
        check_eq("rst_sclk",  32'(sclk_pin),  32'd0);
        check_eq("rst_mosi",  32'(mosi_pin),  32'd0);
        check_eq("rst_busy",  32'(hif.busy),  32'd0);
        check_eq("rst_done",  32'(hif.done),  32'd0);
        check_eq("rst_rdata", 32'(hif.rdata), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_txn(1'b0, 7'h15, 8'hA5, 0, "wr15");
        check_eq("wr15_byte0", 32'(last_frame[15:8]), 32'h2A);
        check_eq("wr15_byte1", 32'(last_frame[7:0]),  32'hA5);

        run_txn(1'b1, 7'h03, 8'hFF, 0, "rd03");
        check_eq("rd03_byte0", 32'(last_frame[15:8]), 32'h07);
        check_eq("rd03_rdata", 32'(hif.rdata),        32'h3C);

        run_txn(1'b0, 7'h44, 8'h96, 50, "spur50");
        run_txn(1'b0, 7'h7F, 8'h5A, 0, "lb_wr");
        run_txn(1'b1, 7'h7F, 8'h00, 0, "lb_rd");
        check_eq("lb_rdata", 32'(hif.rdata), 32'h5A);

        // Abort a read mid-frame, with start asserted alongside reset.
        wait_idle("abort");
        fs0 = frames_seen;
        hif.start = 1'b1; hif.rw = 1'b1; hif.addr = 7'h03; hif.wdata = 8'h00;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            hif.start = 1'b0;
        end
        check_eq("abort_pre_rdata", 32'(hif.rdata), 32'(exp_rdata));
        reset_n = 1'b0; hif.start = 1'b1;
        @(negedge clk);
        check_eq("abort_cs",    32'(cs_pin),    32'd1);
        check_eq("abort_sclk",  32'(sclk_pin),  32'd0);
        check_eq("abort_mosi",  32'(mosi_pin),  32'd0);
        check_eq("abort_busy",  32'(hif.busy),  32'd0);
        check_eq("abort_done",  32'(hif.done),  32'd0);
        check_eq("abort_rdata", 32'(hif.rdata), 32'd0);
        reset_n = 1'b1; hif.start = 1'b0;
        exp_rdata = 8'h00;
        dn = 0; csl = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (hif.done) dn++;
            if (!cs_pin) csl++;
        end
        check_eq("abort_no_done",   32'(dn),          32'd0);
        check_eq("abort_start_ign", 32'(csl),         32'd0);
        check_eq("abort_rdata_kept",32'(hif.rdata),   32'd0);
        check_eq("abort_no_frame",  32'(frames_seen), 32'(fs0));

        for (int i = 0; i < 6; i++) begin
            logic       r_rw;
            logic [6:0] r_a;
            logic [7:0] r_wd;
            int         r_spur;
            r_rw   = 1'($urandom);
            r_a    = 7'($urandom);
            r_wd   = 8'($urandom);
            r_spur = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 270)) : 0;
            run_txn(r_rw, r_a, r_wd, r_spur, $sformatf("rnd%0d", i));
        end

        // start held high: frames repeat every T_LEN cycles.
        wait_idle("b2b");
        hif.start = 1'b1; hif.rw = 1'b0; hif.addr = 7'h22; hif.wdata = 8'hC3;
        for (int c = 1; c <= 3 * T_LEN + 2; c++) begin
            @(negedge clk);
            if (hif.done) dq.push_back(c);
        end
        hif.start = 1'b0;
        check_eq("b2b_count", 32'(dq.size()), 32'd3);
        for (int i = 0; i < dq.size() && i < 3; i++) begin
            check_eq($sformatf("b2b_done%0d", i), 32'(dq[i]), 32'(34 * HP + 1 + i * T_LEN));
        end
        check_eq("b2b_mem", 32'(mem[7'h22]), 32'hC3);
        wait_idle("b2b_end");

        check_eq("pin_protocol", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 8: clk cycles per SCLK half-period; legal range 4..255.
REQ-002 clk  input  1  system (FPGA) clock; all logic on rising edge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request a transaction; accepted only when busy=0.
REQ-005 rw  input  1  1 = read, 0 = write.
REQ-006 addr  input  7  target memory address.
REQ-007 wdata  input  8  write data, ignored for reads.
REQ-008 busy  output  1  high from the cycle after acceptance until ready for the next start.
REQ-009 done  output  1  one-cycle pulse at end of transaction.
REQ-010 rdata  output  8  last read byte, held until the next read completes.
REQ-011 sclk_pin  output  1  SPI clock, idle low.
REQ-012 cs_pin  output  1  SPI chip select, active low, idle high.
REQ-013 mosi_pin  output  1  master out, slave in.
REQ-014 miso_pin  input  1  master in, slave out.

Function
REQ-015 On acceptance (start=1, busy=0, cycle 0), SHALL latch addr, rw and wdata; later input changes have no effect on the frame.
REQ-016 Frame SHALL be 16 bits, MSB first: byte0 = {addr[6:0], rw}, then byte1 = wdata for a write or 8'h00 for a read.
REQ-017 Cycle 1: cs_pin=0, busy=1, sclk_pin=0, mosi_pin=frame bit 15.
REQ-018 SETUP: sclk_pin SHALL stay low for HALF_PERIOD cycles after cs_pin falls; then 16 SCLK periods follow, each high for HALF_PERIOD and then low for HALF_PERIOD cycles.
REQ-019 mosi_pin SHALL change only in the cycle where sclk_pin falls, presenting the next frame bit.
REQ-020 mosi_pin SHALL be stable across every rising edge of sclk_pin.
REQ-021 miso_pin SHALL be sampled in the last clk cycle of each high phase of SCLK periods 9..16, shifted MSB first.
REQ-022 For reads, the 8 sampled bits SHALL be written to rdata in the same cycle done rises; for writes, rdata is unchanged.
REQ-023 HOLD: after the 16th falling edge, cs_pin SHALL stay low for HALF_PERIOD cycles; cs_pin is low from cycle 1 through cycle 34*HALF_PERIOD inclusive.
REQ-024 In cycle 34*HALF_PERIOD+1: cs_pin=1, done=1, mosi_pin=0.
REQ-025 GAP: busy SHALL remain high for HALF_PERIOD further cycles after done.
REQ-026 busy SHALL fall at cycle 35*HALF_PERIOD+1; start is accepted from that cycle onward.
REQ-027 start while busy=1 SHALL be ignored, neither queued nor corrupting the current frame.
REQ-028 start held high continuously SHALL produce back-to-back transactions separated by the GAP.
REQ-029 States: IDLE -> SETUP -> SHIFT_HI <-> SHIFT_LO (16 periods) -> HOLD -> GAP -> IDLE; no other transitions except reset.
REQ-030 The half-period counter SHALL count 0..HALF_PERIOD-1 and wrap, with no drift across phases.
REQ-031 The bit counter SHALL count 0..15 and never wrap past 15 within a frame.

Reset
REQ-032 reset_n=0 at a clock edge SHALL force the following next cycle, regardless of state including mid-frame: IDLE, cs_pin=1, sclk_pin=0, mosi_pin=0, busy=0, done=0, rdata=8'h00, all counters 0.
REQ-033 An aborted frame SHALL produce no done pulse and no rdata update.
REQ-034 start asserted together with reset_n=0 SHALL be ignored.

Structure
REQ-035 Shared package SHALL hold: the state encoding, FRAME_BITS=16, ADDR_BITS=7, DATA_BITS=8, RW_READ=1'b1.
REQ-036 One sub-module, spi_sclk_gen, SHALL hold the half-period counter and emit single-cycle rise/fall/sample strobes; the FSM and shift logic stay in spi_master.

Verification
REQ-037 HALF_PERIOD=8, write addr=7'h15 wdata=8'hA5 -> MOSI sampled on SCLK rises = 8'h2A then 8'hA5; cs_pin low for cycles 1..272; done at cycle 273; rdata unchanged.
REQ-038 Read addr=7'h03 with a MISO model returning 8'h3C on falling edges of periods 8..15 -> byte0 = 8'h07, rdata=8'h3C at done.
REQ-039 start pulsed again at cycle 50 of a transaction -> ignored, single done; new start at cycle 281 (busy low) accepted.
REQ-040 reset_n=0 at cycle 100 of a read -> next cycle cs_pin=1, sclk_pin=0, busy=0, rdata=8'h00; no done.
REQ-041 Loopback against the team's SPI memory block with HALF_PERIOD=8: write 8'h5A to 7'h7F, then read 7'h7F -> rdata=8'h5A.
REQ-042 Assertion throughout all tests: mosi_pin never changes while sclk_pin=1, and cs_pin never toggles while sclk_pin=1.
